keccak_padder: RTL and testbench
================================

KECCAK_PADDER -- requirements
Module: keccak_padder

Interface
REQ-001 SHALL use parameter N, default 64, word width in bits, imported from pkg_keccak; no local parameters.
REQ-002 SHALL have Clock  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have Reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have Msg_in  input  N  message word; byte 0 is bits [7:0].
REQ-005 SHALL have Msg_in_valid  input  1  Msg_in is presented this cycle.
REQ-006 SHALL have Msg_in_last  input  1  current word is the final word of the message.
REQ-007 SHALL have Msg_in_bytes  input  4  count of valid bytes in the last word, 0..8; values above 8 are treated as 8; ignored when Msg_in_last=0.
REQ-008 SHALL have Msg_in_ready  output  1  the message word is accepted this cycle when Msg_in_valid is also high.
REQ-009 SHALL have Din_buffer_in  output  N  formatted word sent to the absorb buffer.
REQ-010 SHALL have Din_buffer_in_valid  output  1  Din_buffer_in is valid.
REQ-011 SHALL have Din_buffer_full  input  1  absorb buffer is full; no transfer occurs while high.
REQ-012 SHALL have Ready  input  1  permutation ready; the buffer releases a full block when this is high.
REQ-013 SHALL have Last_block  output  1  the block currently held in the buffer is the final block of the message.
REQ-014 SHALL have Dout_buffer_out_valid  input  1  digest word output strobe from the buffer.

Function
REQ-015 SHALL count a word transfer only when Din_buffer_in_valid=1 and Din_buffer_full=0; a 4-bit position counter SHALL advance per transfer and wrap 15->0.
REQ-016 SHALL implement states ABSORB, PAD, LAST and DRAIN, with ABSORB at position 0 as the idle state.
REQ-017 In ABSORB, Din_buffer_in_valid SHALL equal Msg_in_valid, Msg_in_ready SHALL equal ~Din_buffer_full, and there SHALL be zero latency from Msg_in to Din_buffer_in (combinational path).
REQ-018 A non-last word SHALL pass through unchanged.
REQ-019 For the last word, bytes at index >= k (k = Msg_in_bytes) SHALL be zero, and byte k SHALL be PAD_BYTE when k<8.
REQ-020 When the last word sits at position 15 with k<8, byte 7 SHALL additionally be ORed with 0x80 (0x81 when k=7), and the next state SHALL be LAST.
REQ-021 When the last word sits at position p<15, or has k=8, the next state SHALL be PAD.
REQ-022 In PAD, the padder SHALL emit words until position 15 inclusive: PAD_BYTE in byte 0 if the last word had k=8, zeros elsewhere, and byte 7 of position 15 ORed with 0x80; Msg_in_ready SHALL be 0; after position 15 transfers, the next state SHALL be LAST.
REQ-023 In LAST, Last_block SHALL be 1, Din_buffer_in_valid SHALL be 0 and Msg_in_ready SHALL be 0; the next state SHALL be DRAIN on Din_buffer_full=1 and Ready=1.
REQ-024 In DRAIN, Msg_in_ready SHALL be 0; the state SHALL return to ABSORB at position 0 on the first cycle Dout_buffer_out_valid=0 after it has been seen high.
REQ-025 Last_block SHALL be 0 in every state other than LAST.
REQ-026 Din_buffer_in SHALL be zero whenever Din_buffer_in_valid=0.

Reset
REQ-027 Reset SHALL force state ABSORB, position 0 and the DRAIN seen flag to 0; consequently Msg_in_ready=~Din_buffer_full, Din_buffer_in_valid=0 (with Msg_in_valid low), Din_buffer_in=0 and Last_block=0.
REQ-028 Reset asserted mid-message or mid-PAD SHALL discard all progress; the next message SHALL start at position 0.

Configuration
REQ-029 With macro KECCAK_SHA3_PAD_EN defined, PAD_BYTE SHALL be 0x06 (SHA-3 domain suffix); without it, PAD_BYTE SHALL be 0x01 (original Keccak pad10*1).

Structure
REQ-030 pkg_keccak SHALL hold N, RATE_WORDS=16, the PAD_BYTE/PAD_LAST constants and the padder state enum typedef.
REQ-031 The byte mask/pad formatting SHALL be a combinational sub-module named keccak_pad_word; the FSM and counter SHALL live in keccak_padder.

Verification (N=64, without KECCAK_SHA3_PAD_EN)
REQ-032 Empty message (last, k=0, Msg_in=all ones) -> word0=0x0000000000000001, words 1-14=0, word15=0x8000000000000000, Last_block high until Ready&&full.
REQ-033 "abc" (Msg_in=0x0000000000636261, k=3, last) -> word0=0x0000000001636261, word15=0x8000000000000000.
REQ-034 128-byte message (16 words, last k=8) -> first block passes unchanged with Last_block=0; a second block follows with word0=0x01 and word15=0x80<<56; Last_block is set only after the second block.
REQ-035 127-byte message (position 15, k=7, Msg_in=0x00FFFFFFFFFFFFFF) -> word15=0x81FFFFFFFFFFFFFF, goes directly to LAST, no extra block.
REQ-036 Din_buffer_full held high for 10 cycles mid-block -> Msg_in_ready=0 throughout, no word dropped or duplicated, position counter unchanged.
REQ-037 Reset pulsed during PAD at position 7 -> Last_block=0 and Din_buffer_in=0 immediately; the next message's first word is placed at position 0.

Source files
------------

// File: rtl/pkg_keccak.sv
// ============================================================================
// Module      : pkg_keccak
// Description : Shared word width, rate, padding constants, padder state type
//               and byte-count helper for the Keccak padder.
//               Build macro: KECCAK_SHA3_PAD_EN selects the SHA-3 domain
//               suffix (0x06) as PAD_BYTE instead of Keccak pad10*1 (0x01).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pkg_keccak;

    parameter int N          = 64;
    localparam int RATE_WORDS = 16;

    // Bytes per message word and the position of the final word in a block
    localparam logic [3:0] WORD_BYTES = 4'(N / 8);
    localparam logic [3:0] LAST_POS   = 4'(RATE_WORDS - 1);

`ifdef KECCAK_SHA3_PAD_EN
    localparam logic [7:0] PAD_BYTE = 8'h06;
`else
    localparam logic [7:0] PAD_BYTE = 8'h01;
`endif
    localparam logic [7:0] PAD_LAST = 8'h80;

    typedef enum logic [1:0] {
        ABSORB = 2'd0,
        PAD    = 2'd1,
        LAST   = 2'd2,
        DRAIN  = 2'd3
    } padder_state_t;

    // Byte counts beyond a full word are treated as a full word
    function automatic logic [3:0] clamp_bytes(input logic [3:0] k);
        return (k > WORD_BYTES) ? WORD_BYTES : k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keccak_pad_word.sv
// ============================================================================
// Module      : keccak_pad_word
// Description : Combinational word formatter. Keeps the low i_keep_bytes
//               bytes of i_data, optionally places PAD_BYTE directly above
//               them, and optionally ORs PAD_LAST into the top byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keccak_pad_word
    import pkg_keccak::*;
(
    input  logic [N-1:0] i_data,
    input  logic [3:0]   i_keep_bytes,
    input  logic         i_pad_en,
    input  logic         i_final_en,
    output logic [N-1:0] o_word
);

    // Byte-wise mask, pad insertion and final-bit merge
    always_comb begin
        o_word = '0;
        for (int i = 0; i < N / 8; i++) begin
            if (4'(i) < i_keep_bytes) begin
                o_word[8*i +: 8] = i_data[8*i +: 8];
            end else if (i_pad_en && (4'(i) == i_keep_bytes)) begin
                o_word[8*i +: 8] = PAD_BYTE;
            end
        end
        if (i_final_en) begin
            o_word[N-1 -: 8] = o_word[N-1 -: 8] | PAD_LAST;
        end
    end

endmodule

`default_nettype wire

// File: rtl/keccak_padder.sv
// ============================================================================
// Module      : keccak_padder
// Description : Streams message words into the Keccak absorb buffer, applying
//               multi-rate padding on the final word and emitting extra pad
//               words up to the end of the rate block. Flags the final block
//               and waits for the digest to drain before accepting a new
//               message. Build macro KECCAK_SHA3_PAD_EN (see pkg_keccak).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keccak_padder
    import pkg_keccak::*;
(
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] Msg_in,
    input  logic         Msg_in_valid,
    input  logic         Msg_in_last,
    input  logic [3:0]   Msg_in_bytes,
    output logic         Msg_in_ready,
    output logic [N-1:0] Din_buffer_in,
    output logic         Din_buffer_in_valid,
    input  logic         Din_buffer_full,
    input  logic         Ready,
    output logic         Last_block,
    input  logic         Dout_buffer_out_valid
);

    padder_state_t r_state;
    logic [3:0]    r_pos;
    logic          r_drain_seen;
    logic          r_pad_pending;   // first pad word must carry PAD_BYTE in byte 0
    logic          r_last_block;

    logic [3:0]    w_k;
    logic          w_short;
    logic          w_at_end;
    logic          w_xfer;
    logic [3:0]    w_keep;
    logic          w_pad_en;
    logic          w_final_en;
    logic [N-1:0]  w_word;

    assign w_k      = clamp_bytes(Msg_in_bytes);
    assign w_short  = (w_k != WORD_BYTES);
    assign w_at_end = (r_pos == LAST_POS);
    assign w_xfer   = Din_buffer_in_valid && !Din_buffer_full;

    // Handshake and formatter controls decoded from the current state
    always_comb begin
        Msg_in_ready        = 1'b0;
        Din_buffer_in_valid = 1'b0;
        w_keep              = '0;
        w_pad_en            = 1'b0;
        w_final_en          = 1'b0;
        case (r_state)
            ABSORB: begin
                Msg_in_ready        = !Din_buffer_full;
                Din_buffer_in_valid = Msg_in_valid;
                if (Msg_in_last) begin
                    w_keep     = w_k;
                    w_pad_en   = w_short;
                    w_final_en = w_short && w_at_end;
                end else begin
                    w_keep     = WORD_BYTES;
                end
            end
            PAD: begin
                Din_buffer_in_valid = 1'b1;
                w_pad_en            = r_pad_pending;
                w_final_en          = w_at_end;
            end
            default: begin
            end
        endcase
    end

    keccak_pad_word u_pad_word (
        .i_data       (Msg_in),
        .i_keep_bytes (w_keep),
        .i_pad_en     (w_pad_en),
        .i_final_en   (w_final_en),
        .o_word       (w_word)
    );

    assign Din_buffer_in = Din_buffer_in_valid ? w_word : '0;
    assign Last_block    = r_last_block;

    // Padder FSM, block position counter and registered final-block flag
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state       <= ABSORB;
            r_pos         <= '0;
            r_drain_seen  <= 1'b0;
            r_pad_pending <= 1'b0;
            r_last_block  <= 1'b0;
        end else begin
            case (r_state)
                ABSORB: begin
                    if (w_xfer) begin
                        r_pos <= r_pos + 4'd1;
                        if (Msg_in_last) begin
                            if (w_short && w_at_end) begin
                                r_state      <= LAST;
                                r_last_block <= 1'b1;
                            end else begin
                                r_state       <= PAD;
                                r_pad_pending <= !w_short;
                            end
                        end
                    end
                end
                PAD: begin
                    if (w_xfer) begin
                        r_pos         <= r_pos + 4'd1;
                        r_pad_pending <= 1'b0;
                        if (w_at_end) begin
                            r_state      <= LAST;
                            r_last_block <= 1'b1;
                        end
                    end
                end
                LAST: begin
                    if (Din_buffer_full && Ready) begin
                        r_state      <= DRAIN;
                        r_last_block <= 1'b0;
                        r_drain_seen <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (Dout_buffer_out_valid) begin
                        r_drain_seen <= 1'b1;
                    end else if (r_drain_seen) begin
                        r_state      <= ABSORB;
                        r_pos        <= '0;
                        r_drain_seen <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ABSORB;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_keccak_padder.sv
// ============================================================================
// Module      : tb_keccak_padder
// Description : Self-checking bench for keccak_padder. Expected block streams
//               come from a byte-level pad10*1 model over the whole message.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keccak_padder;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [63:0] Msg_in = '0;
    logic        Msg_in_valid = 1'b0;
    logic        Msg_in_last = 1'b0;
    logic [3:0]  Msg_in_bytes = '0;
    logic        Msg_in_ready;
    logic [63:0] Din_buffer_in;
    logic        Din_buffer_in_valid;
    logic        Din_buffer_full = 1'b0;
    logic        Ready = 1'b0;
    logic        Last_block;
    logic        Dout_buffer_out_valid = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [7:0]  msg_b[$];
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int          lb_during_xfer = 0;

    keccak_padder dut (
        .Clock                 (Clock),
        .Reset                 (Reset),
        .Msg_in                (Msg_in),
        .Msg_in_valid          (Msg_in_valid),
        .Msg_in_last           (Msg_in_last),
        .Msg_in_bytes          (Msg_in_bytes),
        .Msg_in_ready          (Msg_in_ready),
        .Din_buffer_in         (Din_buffer_in),
        .Din_buffer_in_valid   (Din_buffer_in_valid),
        .Din_buffer_full       (Din_buffer_full),
        .Ready                 (Ready),
        .Last_block            (Last_block),
        .Dout_buffer_out_valid (Dout_buffer_out_valid)
    );

    always #5 Clock = ~Clock;

    // Buffer-side monitor: records every word that will transfer on the next edge
    always @(negedge Clock) begin
        if (!Reset && Din_buffer_in_valid && !Din_buffer_full) begin
            got_q.push_back(Din_buffer_in);
            if (Last_block) lb_during_xfer++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: append pad byte, zero-fill to a multiple of 128 bytes, set top bit of last byte
    task automatic build_expected();
        logic [7:0]  p[$];
        logic [63:0] v;
        p = msg_b;
`ifdef KECCAK_SHA3_PAD_EN
        p.push_back(8'h06);
`else
        p.push_back(8'h01);
`endif
        while ((p.size() % 128) != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        exp_q.delete();
        for (int w = 0; w < p.size() / 8; w++) begin
            v = '0;
            for (int b = 0; b < 8; b++) v[8*b +: 8] = p[8*w + b];
            exp_q.push_back(v);
        end
    endtask

    task automatic fill_random(input int len);
        msg_b.delete();
        for (int i = 0; i < len; i++) msg_b.push_back(8'($urandom));
    endtask

    task automatic present_word(input logic [63:0] w, input bit last, input logic [3:0] k,
                                input int stall, input bit jitter);
        bit done;
        Msg_in = w; Msg_in_last = last; Msg_in_bytes = k; Msg_in_valid = 1'b1;
        if (stall > 0) begin
            Din_buffer_full = 1'b1;
            for (int c = 0; c < stall; c++) begin
                @(negedge Clock);
                check("stall_ready", {63'd0, Msg_in_ready}, 64'd0);
                @(posedge Clock); #1;
            end
            Din_buffer_full = 1'b0;
        end
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (jitter) Din_buffer_full = ($urandom_range(0, 3) == 0);
            @(negedge Clock);
            done = Msg_in_ready && !Din_buffer_full;
            @(posedge Clock); #1;
        end
        if (!done) check("accept_timeout", {63'd0, done}, 64'd1);
        Din_buffer_full = 1'b0;
        Msg_in_valid = 1'b0; Msg_in_last = 1'b0; Msg_in = '0;
    endtask

    task automatic send_message(input int stall_word, input bit jitter, input bit ones_fill);
        int          nw;
        int          idx;
        logic [63:0] v;
        bit          last;
        logic [3:0]  k;
        nw = (msg_b.size() == 0) ? 1 : (msg_b.size() + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 8; b++) begin
                idx = 8*w + b;
                if (idx < msg_b.size()) v[8*b +: 8] = msg_b[idx];
                else v[8*b +: 8] = ones_fill ? 8'hFF : 8'($urandom);
            end
            last = (w == nw - 1);
            k = last ? 4'(msg_b.size() - 8*w) : 4'($urandom);
            if (last && k == 4'd8 && $urandom_range(0, 1) == 1) k = 4'($urandom_range(8, 15));
            present_word(v, last, k, (w == stall_word) ? 10 : 0, jitter);
        end
    endtask

    // Wait for the final block, compare the stream, then release and drain
    task automatic finish_message(input string tag, input bit jitter);
        bit seen;
        int n;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge Clock);
            seen = Last_block;
            @(posedge Clock); #1;
            if (jitter && !seen) Din_buffer_full = ($urandom_range(0, 3) == 0);
        end
        Din_buffer_full = 1'b0;
        @(negedge Clock);
        check({tag, "_last_block"}, {63'd0, Last_block}, 64'd1);
        check({tag, "_last_valid"}, {63'd0, Din_buffer_in_valid}, 64'd0);
        check({tag, "_last_ready"}, {63'd0, Msg_in_ready}, 64'd0);
        check({tag, "_last_din"}, Din_buffer_in, 64'd0);
        check({tag, "_word_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
        check({tag, "_lb_during_xfer"}, 64'(lb_during_xfer), 64'd0);
        @(posedge Clock); #1;
        Din_buffer_full = 1'b1; Ready = 1'b0;
        @(negedge Clock);
        check({tag, "_hold_without_ready"}, {63'd0, Last_block}, 64'd1);
        @(posedge Clock); #1;
        Ready = 1'b1;
        @(posedge Clock); #1;
        Ready = 1'b0; Din_buffer_full = 1'b0;
        @(negedge Clock);
        check({tag, "_drain_lb"}, {63'd0, Last_block}, 64'd0);
        check({tag, "_drain_ready"}, {63'd0, Msg_in_ready}, 64'd0);
        @(posedge Clock); #1;
        Dout_buffer_out_valid = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        Dout_buffer_out_valid = 1'b0;
        @(negedge Clock);
        check({tag, "_drain_hold"}, {63'd0, Msg_in_ready}, 64'd0);
        @(posedge Clock); #1;
        @(negedge Clock);
        check({tag, "_idle_ready"}, {63'd0, Msg_in_ready}, 64'd1);
        @(posedge Clock); #1;
        got_q.delete();
        lb_during_xfer = 0;
    endtask

    initial begin
        // Reset state
        Reset = 1'b1;
        #1;
        check("rst_ready", {63'd0, Msg_in_ready}, 64'd1);
        check("rst_valid", {63'd0, Din_buffer_in_valid}, 64'd0);
        check("rst_din", Din_buffer_in, 64'd0);
        check("rst_lb", {63'd0, Last_block}, 64'd0);
        Din_buffer_full = 1'b1;
        #1;
        check("rst_ready_full", {63'd0, Msg_in_ready}, 64'd0);
        Din_buffer_full = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(posedge Clock); #1;
        got_q.delete();

        // Empty message with all-ones data
        msg_b.delete();
        build_expected();
        send_message(-1, 1'b0, 1'b1);
        finish_message("empty", 1'b0);

        // "abc"
        msg_b.delete();
        msg_b.push_back(8'h61); msg_b.push_back(8'h62); msg_b.push_back(8'h63);
        build_expected();
        send_message(-1, 1'b0, 1'b0);
        finish_message("abc", 1'b0);

        // 128 bytes: full block then an all-pad block
        fill_random(128);
        build_expected();
        send_message(-1, 1'b0, 1'b0);
        finish_message("len128", 1'b0);

        // 127 bytes of 0xFF: padding fits in word 15
        msg_b.delete();
        for (int i = 0; i < 127; i++) msg_b.push_back(8'hFF);
        build_expected();
        send_message(-1, 1'b0, 1'b0);
        finish_message("len127", 1'b0);

        // 120 bytes: full last word at position 14
        fill_random(120);
        build_expected();
        send_message(-1, 1'b0, 1'b0);
        finish_message("len120", 1'b0);

        // 136 bytes with a 10-cycle buffer-full stall mid-block
        fill_random(136);
        build_expected();
        send_message(5, 1'b0, 1'b0);
        finish_message("stall136", 1'b0);

        // Reset during PAD at position 7
        msg_b.delete();
        msg_b.push_back(8'h11); msg_b.push_back(8'h22);
        send_message(-1, 1'b0, 1'b0);
        begin
            bit reached;
            reached = 1'b0;
            for (int c = 0; c < 100 && !reached; c++) begin
                @(posedge Clock); #1;
                reached = (got_q.size() >= 7);
            end
            check("rstpad_reach", {63'd0, reached}, 64'd1);
        end
        Reset = 1'b1;
        #1;
        check("rstpad_lb", {63'd0, Last_block}, 64'd0);
        check("rstpad_din", Din_buffer_in, 64'd0);
        check("rstpad_valid", {63'd0, Din_buffer_in_valid}, 64'd0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(posedge Clock); #1;
        got_q.delete();
        lb_during_xfer = 0;
        msg_b.delete();
        msg_b.push_back(8'h61); msg_b.push_back(8'h62); msg_b.push_back(8'h63);
        build_expected();
        send_message(-1, 1'b0, 1'b0);
        finish_message("after_rst", 1'b0);

        // Randomized messages with buffer back-pressure
        for (int m = 0; m < 8; m++) begin
            fill_random($urandom_range(0, 300));
            build_expected();
            send_message(($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : -1, 1'b1, 1'b0);
            finish_message($sformatf("rand%0d", m), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
